// File: rtl/rca_pkg.sv
// Shared state type and default widths for the ripple-carry accumulator slice.
package rca_pkg;
  localparam int unsigned RCA_N     = 8;
  localparam int unsigned RCA_CNT_W = 8;

  typedef enum logic {ST_ACC, ST_DONE} state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: carry propagates bit by bit from Cin to Cout.
module ripple_carry_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  logic c;

  always_comb begin
    c   = Cin;
    Sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end
endmodule

// File: rtl/rca_stream_accumulator.sv
// Framed valid/ready accumulator around ripple_carry_adder; emits sum, sticky carry and beat count.
// Build option RCA_ACC_SATURATE_EN: accumulator pins to all ones after the first carry-out in a frame.
module rca_stream_accumulator
  import rca_pkg::*;
#(
  parameter int unsigned N     = RCA_N,
  parameter int unsigned CNT_W = RCA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);
  state_t           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic [N-1:0]     acc_upd;
  logic             sticky_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             accept;

  ripple_carry_adder #(.N(N)) u_adder (
    .A   (acc_q),
    .B   (in_data),
    .Cin (1'b0),
    .Sum (add_sum),
    .Cout(add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC:  if (in_valid && in_last) state_d = ST_DONE;
        ST_DONE: if (out_ready)           state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_DONE);
  end

  assign accept     = in_valid && in_ready && !clr;
  assign sticky_upd = sticky_q | add_cout;
  assign cnt_upd    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef RCA_ACC_SATURATE_EN
  // sticky_q already set means an earlier beat overflowed: stay pinned.
  assign acc_upd = sticky_upd ? '1 : add_sum;
`else
  assign acc_upd = add_sum;
`endif

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    count_d  = count_q;
    if (clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (accept) begin
      if (in_last) begin
        sum_d    = acc_upd;
        carry_d  = sticky_upd;
        count_d  = cnt_upd;
        acc_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
      end else begin
        acc_d    = acc_upd;
        sticky_d = sticky_upd;
        cnt_d    = cnt_upd;
      end
    end
  end

  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_count = count_q;
endmodule

// File: tb/tb_rca_stream_accumulator.sv
// Directed self-checking bench for rca_stream_accumulator (honours RCA_ACC_SATURATE_EN).
module tb_rca_stream_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic [7:0] out_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rca_stream_accumulator #(.N(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Call right after the last beat; out_ready must be 1 so the hand-off follows.
  task automatic expect_result(input string tag, input logic [7:0] s, input logic c,
                               input logic [7:0] n);
    @(negedge clk);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".sum"},   32'(out_sum),   32'(s));
    check_eq({tag, ".carry"}, 32'(out_carry), 32'(c));
    check_eq({tag, ".count"}, 32'(out_count), 32'(n));
    check_eq({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq({tag, ".valid_after"},    32'(out_valid), 32'd0);
    check_eq({tag, ".in_ready_after"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] exp_big;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #3;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.ready", 32'(in_ready),  32'd1);
    check_eq("rst.sum",   32'(out_sum),   32'd0);
    check_eq("rst.carry", 32'(out_carry), 32'd0);
    check_eq("rst.count", 32'(out_count), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);

    // Overflowing frame: 4+133+141+13 wraps to 35 with a carry.
    send(8'd4, 1'b0); send(8'd133, 1'b0); send(8'd141, 1'b0); send(8'd13, 1'b1);
`ifdef RCA_ACC_SATURATE_EN
    expect_result("f1", 8'd255, 1'b1, 8'd4);
`else
    expect_result("f1", 8'd35, 1'b1, 8'd4);
`endif

    send(8'd10, 1'b0); send(8'd2, 1'b1);
    expect_result("f2", 8'd12, 1'b0, 8'd2);
    send(8'd1, 1'b0); send(8'd4, 1'b1);
    expect_result("f3", 8'd5, 1'b0, 8'd2);

    // Back-pressure with a stray beat presented the whole time.
    out_ready = 1'b0;
    send(8'd155, 1'b1);
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold.valid", 32'(out_valid), 32'd1);
      check_eq("hold.sum",   32'(out_sum),   32'd155);
      check_eq("hold.count", 32'(out_count), 32'd1);
      check_eq("hold.carry", 32'(out_carry), 32'd0);
      check_eq("hold.ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    check_eq("hold.valid_after", 32'(out_valid), 32'd0);
    check_eq("hold.ready_after", 32'(in_ready),  32'd1);

    // clr beats a simultaneous last beat; partial frame 200+100 is discarded.
    send(8'd200, 1'b0); send(8'd100, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd55; in_last = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    check_eq("clr.valid", 32'(out_valid), 32'd0);
    check_eq("clr.ready", 32'(in_ready),  32'd1);
    check_eq("clr.sum_kept", 32'(out_sum), 32'd155);
    send(8'd7, 1'b1);
    expect_result("f4", 8'd7, 1'b0, 8'd1);

    // Asynchronous reset mid-frame.
    send(8'd50, 1'b0); send(8'd60, 1'b0);
    #2; rst = 1'b1; #1;
    check_eq("arst.valid", 32'(out_valid), 32'd0);
    check_eq("arst.ready", 32'(in_ready),  32'd1);
    check_eq("arst.sum",   32'(out_sum),   32'd0);
    check_eq("arst.carry", 32'(out_carry), 32'd0);
    check_eq("arst.count", 32'(out_count), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    send(8'd9, 1'b1);
    expect_result("f5", 8'd9, 1'b0, 8'd1);

    // 256 beats of 1: count pins at 255, sum wraps to 0 on the last beat.
    for (int i = 0; i < 256; i++) send(8'd1, (i == 255));
`ifdef RCA_ACC_SATURATE_EN
    exp_big = 8'd255;
`else
    exp_big = 8'd0;
`endif
    expect_result("cnt_sat", exp_big, 1'b1, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
